mips_dmem_io: RTL
=================

# mips_dmem_io

Data-side memory stage sitting directly downstream of the single-cycle MIPS core's data port (`mem_addr`, `mem_write`, `mem_we`, `mem_read`). It serves loads and stores to a local word RAM with combinational read and clocked write. Stores to the MMIO window go into a store FIFO, which drains to an external valid/ready I/O port. The core never stalls: stores to a full FIFO are dropped and flagged.

## Interface
- `RAM_WORDS`, 256: local RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 4: store FIFO entries; power of two, ≥2.
- `MMIO_HI`, 16'hFFFF: value of `mem_addr[31:16]` that selects the MMIO window.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` in 32: byte address from the core ALU.
- `mem_write` in 32: store data from the core.
- `mem_we` in 1: store strobe, one store per cycle when high.
- `mem_read` out 32: load data to the core; combinational.
- `io_valid` out 1: FIFO head entry is valid.
- `io_ready` in 1: external sink accepts the head this cycle.
- `io_addr` out 16: MMIO offset of the head entry.
- `io_data` out 32: store data of the head entry.
- `io_ovf` out 1: sticky overflow flag.

## Operation
- Decode: `mmio = (mem_addr[31:16] == MMIO_HI)`. `ofs = mem_addr[15:0]`. Bits [1:0] are ignored everywhere; word access only.
- RAM region (`!mmio`):
  - Word index is `mem_addr[log2(RAM_WORDS)+1:2]`, so upper bits alias.
  - Store writes at the clock edge.
  - Load returns `ram[index]` combinationally; read-before-write in the same cycle returns old data.
  - RAM contents are not reset.
- STATUS register (`mmio && ofs[15:2]==0`):
  - Load returns `{io_ovf, 15'b0, count[15:0]}`, with count zero-extended.
  - Store with `mem_write[31]=1` clears `io_ovf`. Other bits are ignored. STATUS stores are never queued.
- Queued MMIO store (`mmio && ofs[15:2]!=0 && mem_we`):
  - Pushes `{ofs, mem_write}` if `count < FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the store is dropped and `io_ovf` is set to 1.
- MMIO loads at non-STATUS offsets return 32'h0.
- Pop: when `io_valid && io_ready`. `io_valid = (count != 0)`.
- `io_addr`/`io_data` show the head entry directly from FIFO storage.
- Holding rule: `io_addr`/`io_data` stay stable while `io_valid && !io_ready`.
- Count update: push only → +1; pop only → −1; both → unchanged.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. `count` is `log2(FIFO_DEPTH)+1` bits.
- Order is strict FIFO. No coalescing.

## Timing
- Reset values (immediate on `rst_n` low):
  - `count=0`, read pointer 0, write pointer 0.
  - `io_valid=0`, `io_ovf=0`.
  - `io_addr`/`io_data` are don't-care while `io_valid=0`.
  - `mem_read` follows its combinational decode.
- Reset mid-operation discards all queued entries. No drain.
- Load latency 0: `mem_read` is valid in the same cycle as `mem_addr`.
- Store-to-RAM visibility: the next cycle.
- Push to `io_valid` latency: 1 cycle. A push into an empty FIFO raises `io_valid` after that edge.
- Full with simultaneous pop and push: the push is accepted, `count` stays `FIFO_DEPTH`, and `io_ovf` is unchanged.
- Overflow drop and STATUS clear can't collide: a single store goes to only one target.
- Back-to-back pops: with `io_ready` held high, one entry drains per cycle.

## Structure
- Package `mips_mem_pkg` holds:
  - `STATUS_OFS` (16'h0000)
  - status bit positions (`OVF_BIT=31`, count in [15:0])
  - MMIO window constant defaults
- Sub-module `mips_io_fifo` (parameter `DEPTH`, `WIDTH=48`):
  - inputs `push`, `pop`, `din`
  - outputs `dout`, `count`, `full`, `empty`
  - async active-low reset on the pointers and count only; the storage array is not reset.
- Top level holds the decode, the RAM array, the overflow flag and the `mem_read` mux.

## Test plan
- Reset, then store 0x12345678 to 0x00000010, then load 0x00000010 → `mem_read`=0x12345678 on the cycle after the store. Load 0x00000410 with `RAM_WORDS`=256 → aliases to the same word.
- `io_ready`=0; store 0xA1..0xA4 to 0xFFFF0004..0xFFFF0010 on 4 consecutive cycles → STATUS reads 0x00000004, `io_valid`=1, head `io_addr`=0x0004, `io_data`=0xA1.
- FIFO full with `io_ready`=0; store 0xBB to 0xFFFF0020 → dropped, STATUS=0x80000004. Store 0x80000000 to 0xFFFF0000 → STATUS=0x00000004.
- FIFO full; raise `io_ready` and store 0xCC in the same cycle → push accepted, count stays 4. Drain order is 0xA2, 0xA3, 0xA4, 0xCC, one per cycle, and `io_valid` falls after the last pop.
- Push 3 entries, assert `rst_n`=0 mid-drain → `io_valid`=0 and STATUS=0 immediately. After release, a new push drains correctly from pointer 0.
- Pointer wrap: 10 push/pop pairs with `io_ready`=1 → data order preserved, count never exceeds 1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants, types and helpers for the MIPS data-side memory stage.
package mips_mem_pkg;

  // MMIO register map
  localparam logic [15:0] STATUS_OFS = 16'h0000;

  // STATUS word layout
  localparam int OVF_BIT = 31;
  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 0;

  // Default geometry and MMIO window
  localparam logic [15:0] MMIO_HI_DEFAULT    = 16'hFFFF;
  localparam int          RAM_WORDS_DEFAULT  = 256;
  localparam int          FIFO_DEPTH_DEFAULT = 4;

  // One queued MMIO store: offset in the window plus the store data
  typedef struct packed {
    logic [15:0] ofs;
    logic [31:0] data;
  } io_entry_t;

  localparam int IO_ENTRY_W = $bits(io_entry_t);

  // Where the current access lands
  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_STATUS,
    TGT_MMIO
  } tgt_e;

  // Assemble the STATUS word from the overflow flag and the FIFO occupancy
  function automatic logic [31:0] status_word(input logic ovf, input logic [15:0] cnt);
    logic [31:0] w;
    w                  = '0;
    w[OVF_BIT]         = ovf;
    w[CNT_MSB:CNT_LSB] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mips_io_fifo.sv
// Store FIFO between the core's MMIO stores and the external I/O port.
// The head entry is read straight out of storage. The caller must not push
// when the FIFO is full unless it also pops in the same cycle, and must not
// pop when the FIFO is empty.
module mips_io_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 48,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage write; when full with a simultaneous pop, wr_ptr equals rd_ptr and
  // the departing head slot is reused for the incoming entry
  // NOTE: storage arrays are left unreset; only pointers and count define
  // which entries are live, so clearing the array would add logic for no benefit.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth
  // NOTE: all sequential state uses <= so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mips_dmem_io.sv
// Data-side memory stage for the single-cycle MIPS core: local word RAM with
// combinational read, a STATUS register, and an MMIO store FIFO draining to
// a valid/ready port. The core never stalls; stores to a full FIFO are
// dropped and flagged in a sticky overflow bit.
module mips_dmem_io
  import mips_mem_pkg::*;
#(
  parameter int          RAM_WORDS  = RAM_WORDS_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter logic [15:0] MMIO_HI    = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write,
  input  logic        mem_we,
  output logic [31:0] mem_read,
  output logic        io_valid,
  input  logic        io_ready,
  output logic [15:0] io_addr,
  output logic [31:0] io_data,
  output logic        io_ovf
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]       ofs;
  tgt_e              tgt;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram [RAM_WORDS];

  logic              q_req;
  logic              q_push;
  logic              q_pop;
  logic              q_drop;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  io_entry_t         q_din;
  io_entry_t         q_dout;

  assign ofs     = mem_addr[15:0];
  assign ram_idx = mem_addr[RAM_AW+1:2];

  // Address decode: RAM outside the window, STATUS at word 0 of the window,
  // every other window word is a queued store target
  always_comb begin
    tgt = TGT_RAM;
    if (mem_addr[31:16] == MMIO_HI) begin
      tgt = (ofs[15:2] == STATUS_OFS[15:2]) ? TGT_STATUS : TGT_MMIO;
    end
  end

  // Local RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (tgt == TGT_RAM && mem_we) begin
      ram[ram_idx] <= mem_write;
    end
  end

  // Queue control: a pop in the same cycle frees a slot for a push into a full FIFO
  assign q_req  = (tgt == TGT_MMIO) && mem_we;
  assign q_pop  = io_valid && io_ready;
  assign q_push = q_req && (!q_full || q_pop);
  assign q_drop = q_req && q_full && !q_pop;
  assign q_din  = '{ofs: ofs, data: mem_write};

  mips_io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IO_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign io_valid = !q_empty;
  assign io_addr  = q_dout.ofs;
  assign io_data  = q_dout.data;

  // Sticky overflow: set on a dropped store, cleared by a STATUS store with bit 31 set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_ovf <= 1'b0;
    end else if (q_drop) begin
      io_ovf <= 1'b1;
    end else if (tgt == TGT_STATUS && mem_we && mem_write[OVF_BIT]) begin
      io_ovf <= 1'b0;
    end
  end

  // Load data mux; non-STATUS window reads return zero
  // NOTE: the default assignment first guarantees a value on every path, so no latch.
  always_comb begin
    mem_read = '0;
    unique case (tgt)
      TGT_RAM:    mem_read = ram[ram_idx];
      TGT_STATUS: mem_read = status_word(io_ovf, 16'(q_count));
      default:    mem_read = '0;
    endcase
  end

endmodule
